// File: rtl/pulse_gen_arbiter.sv
// pulse_gen_arbiter: round-robin scheduler sharing one one-shot pulse generator
// among p_NUM_REQ requesters. Launches a pulse, tracks it to completion, then
// enforces an idle gap. Define PULSE_ARB_WATCHDOG_EN to enable the watchdog
// abort (p_WDOG_CYCLES) and the sticky o_err flag; otherwise o_err is tied 0.
module pulse_gen_arbiter #(
    parameter int unsigned p_NUM_REQ     = 4,
    parameter int unsigned p_GAP_CYCLES  = 2,
    parameter int unsigned p_WDOG_CYCLES = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [p_NUM_REQ-1:0] i_req,
    input  logic [p_NUM_REQ-1:0] i_cancel,
    input  logic                 i_pulse,
    output logic                 o_go,
    output logic                 o_stop,
    output logic [p_NUM_REQ-1:0] o_grant,
    output logic [p_NUM_REQ-1:0] o_done,
    output logic [p_NUM_REQ-1:0] o_abrt,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int unsigned IDX_W = $clog2(p_NUM_REQ);
    localparam int unsigned GAP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_ACTIVE,
        ST_GAP
    } state_e;

    // Elaboration-time guard on the supported parameter ranges
    if (p_NUM_REQ < 2 || p_NUM_REQ > 16 || p_GAP_CYCLES > 255 || p_WDOG_CYCLES < 1) begin : g_bad_param
        $error("pulse_gen_arbiter: parameter out of supported range");
    end

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [p_NUM_REQ-1:0] grant_q, grant_d;
    logic [p_NUM_REQ-1:0] done_q, done_d;
    logic [p_NUM_REQ-1:0] abrt_q, abrt_d;
    logic                 go_q, go_d;
    logic                 stop_q, stop_d;
    logic                 busy_q, busy_d;

    logic                 sel_vld;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     ptr_nxt;
    logic                 cancel_hit;
    logic                 finish;

`ifdef PULSE_ARB_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(p_WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 err_q, err_d;
`endif

    // Round-robin pick: first requesting index at or above the pointer, with wrap
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < p_NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % p_NUM_REQ);
            if (!sel_vld && i_req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign ptr_nxt    = (gnt_idx_q == IDX_W'(p_NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
    assign cancel_hit = |(i_cancel & grant_q);

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gap_d     = gap_q;
        grant_d   = grant_q;
        go_d      = 1'b0;
        stop_d    = 1'b0;
        done_d    = '0;
        abrt_d    = '0;
        finish    = 1'b0;
`ifdef PULSE_ARB_WATCHDOG_EN
        wdog_d    = wdog_q;
        err_d     = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_d          = ST_LAUNCH;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gnt_idx_d        = sel_idx;
                    go_d             = 1'b1;
`ifdef PULSE_ARB_WATCHDOG_EN
                    wdog_d           = '0;
`endif
                end
            end
            ST_LAUNCH: begin
                state_d = i_pulse ? ST_ACTIVE : ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (cancel_hit) begin
                    stop_d = 1'b1;
                    abrt_d = grant_q;
                    finish = 1'b1;
                end else if (i_pulse) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cancel_hit) begin
                    stop_d = 1'b1;
                    abrt_d = grant_q;
                    finish = 1'b1;
                end else if (!i_pulse) begin
                    done_d = grant_q;
                    finish = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(p_GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef PULSE_ARB_WATCHDOG_EN
        // Watchdog runs while a pulse is outstanding; a cancel or normal end takes priority
        if (state_q == ST_LAUNCH || state_q == ST_WAIT_HI || state_q == ST_ACTIVE) begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (!finish && wdog_q == WDOG_W'(p_WDOG_CYCLES - 1)) begin
                stop_d = 1'b1;
                abrt_d = grant_q;
                err_d  = 1'b1;
                finish = 1'b1;
            end
        end
`endif

        if (finish) begin
            grant_d = '0;
            ptr_d   = ptr_nxt;
            gap_d   = '0;
            state_d = (p_GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gap_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            abrt_q    <= '0;
            go_q      <= 1'b0;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gap_q     <= gap_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            abrt_q    <= abrt_d;
            go_q      <= go_d;
            stop_q    <= stop_d;
            busy_q    <= busy_d;
        end
    end

`ifdef PULSE_ARB_WATCHDOG_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_go    = go_q;
    assign o_stop  = stop_q;
    assign o_grant = grant_q;
    assign o_done  = done_q;
    assign o_abrt  = abrt_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_pulse_gen_arbiter.sv
// Testbench for pulse_gen_arbiter: a behavioural one-shot generator model,
// a scoreboard of expected grants/outcomes, and per-cycle protocol checks.
module tb_pulse_gen_arbiter;

    localparam int unsigned N         = 4;
    localparam int unsigned PULSE_LEN = 5;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         abort;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] cancel;
    logic         pulse;
    logic         go;
    logic         stop;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic [N-1:0] abrt;
    logic         busy;
    logic         err;
    logic         stuck;

    int   n_checks;
    int   n_errors;
    int   outcomes;
    int   gen_cnt;
    int   since_end;
    int   k;

    exp_t exp_q[$];
    exp_t cur;
    logic cur_vld;
    logic go_prev, stop_prev, pulse_p1, pulse_p2;

    pulse_gen_arbiter #(
        .p_NUM_REQ    (N),
        .p_GAP_CYCLES (2),
        .p_WDOG_CYCLES(8)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_cancel(cancel),
        .i_pulse (pulse),
        .o_go    (go),
        .o_stop  (stop),
        .o_grant (grant),
        .o_done  (done),
        .o_abrt  (abrt),
        .o_busy  (busy),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-shot generator model: PULSE_LEN cycles high after go, killed by stop
    always @(posedge clk or posedge rst) begin
        if (rst)                gen_cnt <= 0;
        else if (go)            gen_cnt <= PULSE_LEN;
        else if (stop)          gen_cnt <= 0;
        else if (gen_cnt != 0)  gen_cnt <= gen_cnt - 1;
    end
    assign pulse = (gen_cnt != 0) && !stuck;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] g, input logic a);
        exp_t e;
        e.grant = g;
        e.abort = a;
        exp_q.push_back(e);
    endtask

    task automatic wait_outcomes(input int target, input int budget);
        int n;
        n = 0;
        while (outcomes < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (outcomes < target) check_eq("outcome_timeout", 32'(outcomes), 32'(target));
    endtask

    task automatic wait_go(input int budget);
        int n;
        n = 0;
        while (!go && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!go) check_eq("go_timeout", 32'(go), 32'd1);
    endtask

    // Monitor: scoreboard pop on launch/completion plus protocol invariants
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cur_vld   = 1'b0;
            go_prev   = 1'b0;
            stop_prev = 1'b0;
            pulse_p1  = 1'b0;
            pulse_p2  = 1'b0;
            since_end = -1;
        end else begin
            check_eq("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check_eq("go_stop_excl", 32'(go & stop), 32'd0);
            if (go_prev)   check_eq("go_width", 32'(go), 32'd0);
            if (stop_prev) check_eq("pulse_low_after_stop", 32'(pulse), 32'd0);
            if (go) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    cur     = exp_q.pop_front();
                    cur_vld = 1'b1;
                    check_eq("grant", 32'(grant), 32'(cur.grant));
                    check_eq("busy_on_go", 32'(busy), 32'd1);
                end
            end
            if ((done | abrt) != '0) begin
                if (!cur_vld) begin
                    check_eq("unexpected_end", 32'(done | abrt), 32'd0);
                end else begin
                    check_eq("done", 32'(done), cur.abort ? 32'd0 : 32'(cur.grant));
                    check_eq("abrt", 32'(abrt), cur.abort ? 32'(cur.grant) : 32'd0);
                    check_eq("stop_with_end", 32'(stop), 32'(cur.abort));
                    check_eq("grant_cleared", 32'(grant), 32'd0);
                    if (!cur.abort) check_eq("pulse_fell", 32'({pulse_p2, pulse_p1}), 32'b10);
                    cur_vld   = 1'b0;
                    outcomes++;
                    since_end = 0;
                end
            end else if (since_end >= 0) begin
                since_end++;
                if (since_end == 1) check_eq("busy_in_gap", 32'(busy), 32'd1);
                if (since_end == 2) begin
                    check_eq("busy_after_gap", 32'(busy), 32'd0);
                    since_end = -1;
                end
            end
            go_prev   = go;
            stop_prev = stop;
            pulse_p2  = pulse_p1;
            pulse_p1  = pulse;
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        outcomes  = 0;
        since_end = -1;
        cur_vld   = 1'b0;
        rst       = 1'b1;
        req       = '0;
        cancel    = '0;
        stuck     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_busy",  32'(busy),  32'd0);
        check_eq("rst_go",    32'(go),    32'd0);
        check_eq("rst_stop",  32'(stop),  32'd0);
        check_eq("rst_done",  32'(done),  32'd0);
        check_eq("rst_abrt",  32'(abrt),  32'd0);
        check_eq("rst_err",   32'(err),   32'd0);
        rst = 1'b0;

        // Single requester, normal completion, launch latency
        @(negedge clk);
        push_exp(4'b0001, 1'b0);
        req = 4'b0001;
        @(posedge clk);
        #2;
        check_eq("t1_go_latency", 32'(go), 32'd1);
        check_eq("t1_grant", 32'(grant), 32'b0001);
        wait_outcomes(1, 50);
        req = '0;
        repeat (4) @(negedge clk);

        // Cancel by the grantee two cycles after go
        push_exp(4'b0100, 1'b1);
        req = 4'b0100;
        wait_go(20);
        @(negedge clk);
        @(negedge clk);
        cancel = 4'b0100;
        wait_outcomes(2, 50);
        cancel = '0;
        req    = '0;
        repeat (4) @(negedge clk);

        // Cancel from a non-grantee is ignored
        push_exp(4'b0100, 1'b0);
        req    = 4'b0100;
        cancel = 4'b0010;
        wait_outcomes(3, 50);
        req    = '0;
        cancel = '0;
        repeat (4) @(negedge clk);

        // Asynchronous reset while ACTIVE
        push_exp(4'b0010, 1'b0);
        req = 4'b0010;
        wait_go(20);
        repeat (3) @(negedge clk);
        check_eq("t6_pulse_high", 32'(pulse), 32'd1);
        check_eq("t6_grant_pre", 32'(grant), 32'b0010);
        rst = 1'b1;
        #1;
        check_eq("t6_grant", 32'(grant), 32'd0);
        check_eq("t6_busy",  32'(busy),  32'd0);
        check_eq("t6_go",    32'(go),    32'd0);
        check_eq("t6_stop",  32'(stop),  32'd0);
        check_eq("t6_done",  32'(done),  32'd0);
        check_eq("t6_abrt",  32'(abrt),  32'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All requesters held: round-robin from pointer 0
        push_exp(4'b0001, 1'b0);
        push_exp(4'b0010, 1'b0);
        push_exp(4'b0100, 1'b0);
        push_exp(4'b1000, 1'b0);
        push_exp(4'b0001, 1'b0);
        req = 4'b1111;
        wait_outcomes(8, 200);
        req = '0;
        repeat (10) @(negedge clk);
        check_eq("t2_idle", 32'(busy), 32'd0);
        check_eq("t2_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef PULSE_ARB_WATCHDOG_EN
        // Watchdog abort with the pulse stuck low, then normal service
        stuck = 1'b1;
        push_exp(4'b0001, 1'b1);
        req = 4'b0001;
        wait_go(20);
        k = 0;
        while (!stop && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("wdog_stop_cycles", 32'(k), 32'd8);
        wait_outcomes(9, 20);
        req   = '0;
        stuck = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("wdog_err", 32'(err), 32'd1);
        push_exp(4'b0001, 1'b0);
        req = 4'b0001;
        wait_outcomes(10, 50);
        req = '0;
        repeat (4) @(negedge clk);
        check_eq("wdog_err_sticky", 32'(err), 32'd1);
`else
        check_eq("err_tied_low", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_gen_arbiter.md
Name: pulse_gen_arbiter

Overview:
- Round-robin scheduler that shares one one_shot_pulse_gen instance among p_NUM_REQ requesters.
- Accepts level requests and grants one requester at a time.
- Drives the generator's go/stop controls and tracks the returned pulse to detect completion.
- Reports per-requester done/abort, with a fixed idle gap between consecutive pulses.

Parameters:
p_NUM_REQ, 4, number of requesters (2..16)
p_GAP_CYCLES, 2, idle cycles forced between end of one pulse and next o_go (0..255)
p_WDOG_CYCLES, 64, max cycles from o_go to pulse end before watchdog abort (only with watchdog macro)

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_req  in  p_NUM_REQ  level request per requester; hold until o_done/o_abrt bit seen
i_cancel  in  p_NUM_REQ  cancel request; acts only on current grantee
i_pulse  in  1  o_pulse from the shared pulse generator
o_go  out  1  one-cycle start strobe to pulse generator i_go
o_stop  out  1  one-cycle stop strobe to pulse generator i_stop
o_grant  out  p_NUM_REQ  one-hot owner, all-zero when idle
o_done  out  p_NUM_REQ  one-cycle strobe: grantee's pulse completed normally
o_abrt  out  p_NUM_REQ  one-cycle strobe: grantee's pulse cancelled/aborted
o_busy  out  1  high in any state except IDLE
o_err  out  1  sticky watchdog error flag

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; RR pointer = 0 (requester 0 highest priority first); gap and watchdog counters 0.
- All outputs registered; decisions use values sampled on a rising edge.
- States: IDLE, LAUNCH, WAIT_HI, ACTIVE, GAP.
- IDLE:
  - If any i_req bit is set, select the first set bit searching from pointer upward with wrap.
  - Next cycle: o_grant = that bit, o_go = 1, state LAUNCH.
  - Latency: i_req sampled at edge N -> o_go/o_grant high after edge N+1 edge... i.e. visible in cycle N+1.
- LAUNCH: o_go drops after one cycle; state WAIT_HI.
- WAIT_HI:
  - i_pulse=1 -> ACTIVE.
  - i_pulse already high in LAUNCH -> ACTIVE directly from LAUNCH.
- ACTIVE: i_pulse=0 -> o_done[grantee] strobe one cycle, state GAP.
- Cancel (WAIT_HI or ACTIVE, i_cancel[grantee]=1):
  - o_stop strobe one cycle, o_abrt[grantee] strobe, state GAP.
  - Cancel and pulse fall on the same edge: cancel wins, so o_abrt only, no o_done.
- i_cancel bits of non-grantees are ignored; i_cancel in IDLE/GAP is ignored.
- GAP:
  - o_grant cleared on entry.
  - Pointer = grantee+1 mod p_NUM_REQ.
  - Wait p_GAP_CYCLES cycles, then IDLE.
  - p_GAP_CYCLES=0 -> straight to IDLE.
  - Minimum issue interval is therefore LAUNCH..GAP + 1 IDLE cycle.
- Requester must drop i_req within the GAP window after its done/abrt if no new pulse is wanted. Otherwise it re-enters arbitration at lowest priority; this is not an error.
- i_req deassertion while granted does not cancel; only i_cancel does.
- o_busy = (state != IDLE).
- o_grant is one-hot or zero; never more than one bit.
- o_go and o_stop are never asserted in the same cycle.
- Reset mid-pulse: outputs clear immediately. The pulse generator is reset by its own reset; no stop strobe is issued.

Optional Feature:
Macro PULSE_ARB_WATCHDOG_EN.
- Defined:
  - Counter clears on o_go and increments in LAUNCH/WAIT_HI/ACTIVE.
  - When count reaches p_WDOG_CYCLES: o_stop strobe, o_abrt[grantee] strobe, o_err set (sticky until i_rst), state GAP.
  - Cancel on the same cycle: treated as cancel, o_err not set.
- Undefined:
  - No counter logic; o_err tied 0.
  - WAIT_HI/ACTIVE wait indefinitely.

Test Plan:
- Reset then i_req=4'b0001 held, generator p_PULSE_LENGTH=5 -> o_go one cycle, o_grant=0001, o_done=0001 one cycle after i_pulse falls, o_busy low 2 cycles after GAP entry (p_GAP_CYCLES=2).
- i_req=4'b1111 held continuously -> grants in order 0001,0010,0100,1000,0001; exactly one o_done per grant; o_grant never multi-hot.
- i_req=4'b0100 granted, i_cancel=4'b0100 two cycles after o_go -> o_stop one cycle, o_abrt=0100, no o_done, pulse generator output low next cycle.
- i_cancel=4'b0010 while requester 2 is granted -> ignored; normal o_done=0100.
- With PULSE_ARB_WATCHDOG_EN and p_WDOG_CYCLES=8, i_pulse stuck 0 -> o_stop and o_abrt at count 8, o_err=1 sticky; next request still serviced.
- i_rst asserted during ACTIVE -> o_grant, o_busy, o_go, o_stop, o_done, o_abrt all 0 asynchronously; pointer back to 0.
